// File: rtl/vram_frame_reader.sv
// Raster-order VRAM reader: issues one read per free buffer slot and streams pixels out
// through a 2-entry FIFO that absorbs the one-cycle RAM read latency.
module vram_frame_reader #(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int VRAM_W         = 16,
    localparam int VRAM_L        = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    localparam int AW            = $clog2(VRAM_L)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic [AW-1:0]     vram_rd_addr,
    input  logic [VRAM_W-1:0] vram_rd_data,
    output logic [VRAM_W-1:0] pixel_data,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              pixel_last
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q;
    logic [1:0]        count_q;
    logic              inflight_q, inflight_last_q;
    logic [VRAM_W-1:0] head_data_q, tail_data_q;
    logic              head_last_q, tail_last_q;
    logic              frame_done_q;
    logic              pop, push, issue, at_last;

    assign pixel_valid  = (count_q != 2'd0);
    assign pixel_data   = head_data_q;
    assign pixel_last   = head_last_q;
    assign vram_rd_addr = addr_q;
    assign frame_done   = frame_done_q;

    assign pop     = pixel_valid & pixel_ready;
    assign push    = inflight_q;
    assign at_last = (addr_q == AW'(VRAM_L - 1));
    // Reserve a slot for every read in flight so a capture can never overflow the buffer.
    assign issue   = (state_q == S_STREAM) && ena &&
                     (({1'b0, count_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_STREAM;
            S_STREAM: if (issue && at_last) state_d = S_DRAIN;
            S_DRAIN:  if (pop && head_last_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                addr_q <= '0;
            end else if (issue && !at_last) begin
                addr_q <= addr_q + AW'(1);
            end
            inflight_q      <= issue;
            inflight_last_q <= issue & at_last;
            frame_done_q    <= (state_q == S_DRAIN) && pop && head_last_q;
        end
    end

    // Head/tail FIFO; a push with pop at occupancy 1 writes straight into the head.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count_q     <= 2'd0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_data_q <= vram_rd_data;
                        head_last_q <= inflight_last_q;
                    end else begin
                        tail_data_q <= vram_rd_data;
                        tail_last_q <= inflight_last_q;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_data_q <= tail_data_q;
                    head_last_q <= tail_last_q;
                    count_q     <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_data_q <= vram_rd_data;
                        head_last_q <= inflight_last_q;
                    end else begin
                        head_data_q <= tail_data_q;
                        head_last_q <= tail_last_q;
                        tail_data_q <= vram_rd_data;
                        tail_last_q <= inflight_last_q;
                    end
                end
                default: ;
            endcase
        end
    end

    occupancy_bound: assert property (@(posedge clk) disable iff (!rstb)
        ({1'b0, count_q} + {2'b0, inflight_q}) <= 3'd2);

endmodule

// File: tb/tb_vram_frame_reader.sv
// Bench for vram_frame_reader: a 4x3 instance checked cycle-by-cycle from a table, and an
// 80x70 instance checked by an in-order scoreboard under random backpressure and corner cases.
module tb_vram_frame_reader;

    localparam int A_W = 4;
    localparam int A_H = 3;
    localparam int A_L = A_W * A_H;
    localparam int A_AW = $clog2(A_L);
    localparam int B_W = 80;
    localparam int B_H = 70;
    localparam int B_L = B_W * B_H;
    localparam int B_AW = $clog2(B_L);

    logic clk;
    int checks = 0;
    int failures = 0;

    logic            a_rstb, a_ena, a_start, a_ready;
    logic            a_busy, a_done, a_valid, a_last;
    logic [A_AW-1:0] a_addr;
    logic [15:0]     a_rd, a_pdata;

    logic            b_rstb, b_ena, b_start, b_ready;
    logic            b_busy, b_done, b_valid, b_last;
    logic [B_AW-1:0] b_addr;
    logic [15:0]     b_rd, b_pdata;
    int              b_rmode;

    vram_frame_reader #(.DISPLAY_WIDTH(A_W), .DISPLAY_HEIGHT(A_H), .VRAM_W(16)) dut_a (
        .clk(clk), .rstb(a_rstb), .ena(a_ena), .start(a_start), .busy(a_busy),
        .frame_done(a_done), .vram_rd_addr(a_addr), .vram_rd_data(a_rd),
        .pixel_data(a_pdata), .pixel_valid(a_valid), .pixel_ready(a_ready),
        .pixel_last(a_last)
    );

    vram_frame_reader #(.DISPLAY_WIDTH(B_W), .DISPLAY_HEIGHT(B_H), .VRAM_W(16)) dut_b (
        .clk(clk), .rstb(b_rstb), .ena(b_ena), .start(b_start), .busy(b_busy),
        .frame_done(b_done), .vram_rd_addr(b_addr), .vram_rd_data(b_rd),
        .pixel_data(b_pdata), .pixel_valid(b_valid), .pixel_ready(b_ready),
        .pixel_last(b_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-output RAMs holding VRAM[i] = i[15:0].
    always @(posedge clk) a_rd <= 16'(a_addr);
    always @(posedge clk) b_rd <= 16'(b_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (b_rmode)
            0:       b_ready = 1'($urandom_range(0, 1));
            1:       b_ready = 1'b1;
            default: b_ready = 1'b0;
        endcase
    endtask

    // Scoreboard: every accepted pixel must be the next address of the frame, in order.
    int          b_exp = 0;
    int          b_acc = 0;
    int          b_done_cnt = 0;
    logic        b_stall = 1'b0;
    logic        b_prev_done = 1'b0;
    logic [15:0] b_sdata;
    logic        b_slast;

    always @(negedge clk) begin
        if (!b_rstb) begin
            b_exp = 0;
            b_stall = 1'b0;
            b_prev_done = 1'b0;
        end else begin
            if (b_stall)
                check("stall_hold", {15'd0, b_valid, b_last, b_pdata}, {15'd0, 1'b1, b_slast, b_sdata});
            if (b_valid && b_ready) begin
                check("stream_data", 32'(b_pdata), 32'(b_exp[15:0]));
                check("stream_last", 32'(b_last), 32'(b_exp == B_L - 1));
                b_exp = (b_exp == B_L - 1) ? 0 : b_exp + 1;
                b_acc++;
            end
            b_stall = b_valid && !b_ready;
            b_sdata = b_pdata;
            b_slast = b_last;
            if (b_done) b_done_cnt++;
            if (b_done && b_prev_done) check("done_one_cycle", 32'd0, 32'd1);
            b_prev_done = b_done;
        end
    end

    typedef struct {
        logic            start;
        logic            valid;
        logic [15:0]     data;
        logic            last;
        logic            busy;
        logic            done;
        logic            chk_addr;
        logic [A_AW-1:0] addr;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int n;
        int f0, acc0, dc0;
        logic [B_AW-1:0] a0;

        for (int c = 0; c < 17; c++) begin
            vecs[c].start    = (c == 0);
            vecs[c].valid    = (c >= 3) && (c <= A_L + 2);
            vecs[c].data     = 16'(c - 3);
            vecs[c].last     = (c == A_L + 2);
            vecs[c].busy     = (c >= 1) && (c <= A_L + 2);
            vecs[c].done     = (c == A_L + 3);
            vecs[c].chk_addr = (c >= 1);
            vecs[c].addr     = A_AW'((c - 1 > A_L - 1) ? A_L - 1 : c - 1);
        end

        a_rstb = 1'b0; a_ena = 1'b1; a_start = 1'b0; a_ready = 1'b1;
        b_rstb = 1'b0; b_ena = 1'b1; b_start = 1'b0; b_ready = 1'b0; b_rmode = 2;
        repeat (3) tick();
        check("a_reset_busy", 32'(a_busy), 32'd0);
        check("a_reset_valid", 32'(a_valid), 32'd0);
        check("a_reset_addr", 32'(a_addr), 32'd0);
        check("b_reset_outs", {b_busy, b_done, b_valid, b_last, b_pdata}, 32'd0);
        a_rstb = 1'b1;
        b_rstb = 1'b1;
        tick();

        // Small frame, ready high: cycle-exact table.
        for (int c = 0; c < 17; c++) begin
            a_start = vecs[c].start;
            check($sformatf("a_valid[%0d]", c), 32'(a_valid), 32'(vecs[c].valid));
            if (vecs[c].valid) begin
                check($sformatf("a_data[%0d]", c), 32'(a_pdata), 32'(vecs[c].data));
                check($sformatf("a_last[%0d]", c), 32'(a_last), 32'(vecs[c].last));
            end
            check($sformatf("a_busy[%0d]", c), 32'(a_busy), 32'(vecs[c].busy));
            check($sformatf("a_done[%0d]", c), 32'(a_done), 32'(vecs[c].done));
            if (vecs[c].chk_addr)
                check($sformatf("a_addr[%0d]", c), 32'(a_addr), 32'(vecs[c].addr));
            tick();
        end
        a_start = 1'b0;

        // Frame 1: random backpressure.
        b_rmode = 0;
        f0 = b_acc;
        b_start = 1'b1; tick(); b_start = 1'b0;
        n = 0;
        while (!b_done && n < B_L * 8) begin tick(); n++; end
        check("f1_done", 32'(b_done), 32'd1);
        check("f1_busy_at_done", 32'(b_busy), 32'd0);
        check("f1_accepts", 32'(b_acc - f0), 32'(B_L));

        // Frame 2: ena low at address 100, mid-frame start, coincident start at frame_done.
        b_rmode = 1;
        f0 = b_acc;
        tick();
        b_start = 1'b1; tick(); b_start = 1'b0;
        n = 0;
        while (b_addr != B_AW'(100) && n < 400) begin tick(); n++; end
        check("ena_reach_100", 32'(b_addr), 32'd100);
        b_ena = 1'b0;
        acc0 = b_acc;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("ena_addr_hold", 32'(b_addr), 32'd100);
        end
        check("ena_drained_valid", 32'(b_valid), 32'd0);
        check("ena_drain_le2", 32'((b_acc - acc0) <= 2), 32'd1);
        b_ena = 1'b1;
        repeat (50) tick();
        a0 = b_addr;
        b_start = 1'b1; tick(); b_start = 1'b0;
        check("midframe_start_ignored", 32'(b_addr), 32'(a0) + 32'd1);
        n = 0;
        while (!b_done && n < B_L * 2) begin tick(); n++; end
        check("f2_done", 32'(b_done), 32'd1);
        check("f2_accepts", 32'(b_acc - f0), 32'(B_L));
        b_start = 1'b1;
        f0 = b_acc;
        b_rmode = 0;
        tick(); b_start = 1'b0;
        check("coinc_busy_c1", 32'(b_busy), 32'd1);
        check("coinc_valid_c1", 32'(b_valid), 32'd0);
        tick();
        check("coinc_valid_c2", 32'(b_valid), 32'd0);
        tick();
        check("coinc_valid_c3", {b_valid, b_pdata}, {1'b1, 16'd0});

        // Frame 3: asynchronous reset at pixel 5000.
        n = 0;
        while (!((b_acc - f0) >= 5000 && b_valid) && n < 30000) begin tick(); n++; end
        check("rst_reach_5000", 32'((b_acc - f0) >= 5000 && b_valid), 32'd1);
        dc0 = b_done_cnt;
        b_rstb = 1'b0;
        #1;
        check("rst_async_outs", {b_busy, b_done, b_valid, b_last, b_pdata}, 32'd0);
        check("rst_async_addr", 32'(b_addr), 32'd0);
        tick(); tick();
        b_rstb = 1'b1;
        repeat (3) tick();
        check("rst_no_done", 32'(b_done_cnt), 32'(dc0));
        check("rst_idle", 32'(b_busy), 32'd0);

        // Frame 4: restart at 0, then stall on the last pixel.
        b_rmode = 1;
        b_start = 1'b1; tick(); b_start = 1'b0;
        check("restart_busy", 32'(b_busy), 32'd1);
        check("restart_addr", 32'(b_addr), 32'd0);
        n = 0;
        while (!(b_valid && b_last) && n < B_L + 50) begin tick(); n++; end
        check("last_reached", 32'(b_valid && b_last), 32'd1);
        b_rmode = 2;
        b_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("last_stall", {b_valid, b_last, b_busy, b_done, b_pdata},
                  {1'b1, 1'b1, 1'b1, 1'b0, 16'(B_L - 1)});
            check("last_stall_addr", 32'(b_addr), 32'(B_L - 1));
        end
        b_rmode = 1;
        b_ready = 1'b1;
        tick();
        check("last_done_pulse", {b_done, b_busy, b_valid}, {1'b1, 1'b0, 1'b0});
        tick();
        check("last_done_clear", 32'(b_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
